// File: rtl/ifu_sram_rd_slave_pkg.sv
// Shared definitions for the IFU SRAM read slave: response codes and FSM state encoding.
// The response codes are shared with the IFU's response check.
package ifu_sram_rd_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // A decode error outranks a misalignment error.
  function automatic logic [1:0] decodeResp(input logic outOfRange, input logic misaligned);
    if (outOfRange) return RESP_DECERR;
    if (misaligned) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/ifu_lfsr4.sv
// Shared 4-bit Fibonacci LFSR (x^4 + x^3 + 1), seed 4'b0001, steps only when i_advance is high.
// The body exists only when IFU_SRAM_RAND_DELAY_EN is defined, since that is its only user here.
`ifdef IFU_SRAM_RAND_DELAY_EN
module ifu_lfsr4 (
  input  logic       clock,
  input  logic       rstn,
  input  logic       i_advance,
  output logic [3:0] o_value
);

  logic [3:0] r_q;

  always_ff @(posedge clock) begin
    if (!rstn) begin
      r_q <= 4'b0001;
    end else if (i_advance) begin
      r_q <= {r_q[2:0], r_q[3] ^ r_q[2]};
    end
  end

  assign o_value = r_q;

endmodule
`endif

// File: rtl/ifu_sram_array.sv
// 1R1W synchronous SRAM with a registered read port; a same-cycle write to the read word
// is forwarded so the read returns the new data (write-first).
module ifu_sram_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clock,
  input  logic                  i_wrEn,
  input  logic [DEPTH_LOG2-1:0] i_wrAddr,
  input  logic [DATA_WIDTH-1:0] i_wrData,
  input  logic                  i_rdEn,
  input  logic [DEPTH_LOG2-1:0] i_rdAddr,
  output logic [DATA_WIDTH-1:0] o_rdData
);

  logic [DATA_WIDTH-1:0] r_mem [0:(1<<DEPTH_LOG2)-1];
  logic [DATA_WIDTH-1:0] r_rdData;

  always_ff @(posedge clock) begin
    if (i_wrEn) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
    if (i_rdEn) begin
      r_rdData <= (i_wrEn && (i_wrAddr == i_rdAddr)) ? i_wrData : r_mem[i_rdAddr];
    end
  end

  assign o_rdData = r_rdData;

endmodule

// File: rtl/ifu_sram_rd_slave.sv
// AXI-lite style read responder for the IFU fetch channel: decode, wait, then hold the response.
// Optional macro IFU_SRAM_RAND_DELAY_EN replaces the fixed LATENCY with an LFSR-driven 1..15 cycle wait.
module ifu_sram_rd_slave
  import ifu_sram_rd_slave_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                    DEPTH_LOG2 = 10,
  parameter int                    LATENCY    = 1
) (
  input  logic                  clock,
  input  logic                  rstn,
  input  logic [ADDR_WIDTH-1:0] addr_r_addr_i,
  input  logic                  addr_r_valid_i,
  output logic                  addr_r_ready_o,
  output logic [DATA_WIDTH-1:0] r_data_o,
  output logic [1:0]            r_resp_o,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  input  logic                  wr_en_i,
  input  logic [DEPTH_LOG2-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i
);

  localparam int CNT_W = (LATENCY > 15) ? $clog2(LATENCY + 1) : 4;
  localparam logic [CNT_W-1:0] FIXED_TARGET = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

  state_t                r_state;
  logic                  r_valid;
  logic [1:0]            r_resp;
  logic [CNT_W-1:0]      r_cnt;
  logic [DEPTH_LOG2-1:0] r_wordIdx;

  logic [ADDR_WIDTH-1:0] w_offset;
  logic                  w_outOfRange;
  logic                  w_misaligned;
  logic [1:0]            w_respNext;
  logic [DEPTH_LOG2-1:0] w_wordIdx;
  logic                  w_zeroLat;
  logic [CNT_W-1:0]      w_target;
  logic                  w_sampleNow;
  logic [DEPTH_LOG2-1:0] w_rdAddr;
  logic [DATA_WIDTH-1:0] w_rdData;

  // Offsets that wrap below BASE_ADDR are caught by the explicit compare rather than aliased.
  assign w_offset     = addr_r_addr_i - BASE_ADDR;
  assign w_outOfRange = (addr_r_addr_i < BASE_ADDR) || (|w_offset[ADDR_WIDTH-1:DEPTH_LOG2+2]);
  assign w_misaligned = |w_offset[1:0];
  assign w_respNext   = decodeResp(w_outOfRange, w_misaligned);
  assign w_wordIdx    = w_offset[DEPTH_LOG2+1:2];

`ifdef IFU_SRAM_RAND_DELAY_EN
  logic             w_accept;
  logic [3:0]       w_lfsr;
  logic [CNT_W-1:0] r_waitTarget;

  assign w_accept = addr_r_valid_i & addr_r_ready_o;

  ifu_lfsr4 u_lfsr (
    .clock     (clock),
    .rstn      (rstn),
    .i_advance (w_accept),
    .o_value   (w_lfsr)
  );

  // An LFSR value of 0 still waits one cycle.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_waitTarget <= (w_lfsr == 4'd0) ? '0 : CNT_W'(w_lfsr - 4'd1);
    end
  end

  assign w_zeroLat = 1'b0;
  assign w_target  = r_waitTarget;
`else
  assign w_zeroLat = (LATENCY == 0);
  assign w_target  = FIXED_TARGET;
`endif

  assign addr_r_ready_o = (r_state == ST_IDLE) & rstn;

  always_ff @(posedge clock) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_resp  <= RESP_OKAY;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (addr_r_valid_i) begin
            r_resp    <= w_respNext;
            r_wordIdx <= w_wordIdx;
            r_cnt     <= '0;
            r_state   <= w_zeroLat ? ST_RESP : ST_WAIT;
            r_valid   <= w_zeroLat;
          end
        end
        ST_WAIT: begin
          if (r_cnt == w_target) begin
            r_state <= ST_RESP;
            r_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (r_ready_i) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  // The array is read exactly on the edge that enters RESP, so the sample then holds.
  assign w_sampleNow = rstn &
                       (((r_state == ST_IDLE) & addr_r_valid_i & w_zeroLat) |
                        ((r_state == ST_WAIT) & (r_cnt == w_target)));
  assign w_rdAddr    = (r_state == ST_IDLE) ? w_wordIdx : r_wordIdx;

  ifu_sram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_array (
    .clock    (clock),
    .i_wrEn   (wr_en_i & rstn),
    .i_wrAddr (wr_addr_i),
    .i_wrData (wr_data_i),
    .i_rdEn   (w_sampleNow),
    .i_rdAddr (w_rdAddr),
    .o_rdData (w_rdData)
  );

  assign r_valid_o = r_valid;
  assign r_resp_o  = r_resp;
  assign r_data_o  = (r_valid && (r_resp == RESP_OKAY)) ? w_rdData : '0;

endmodule

// File: tb/tb_ifu_sram_rd_slave.sv
// Directed self-checking bench for ifu_sram_rd_slave; a LATENCY=1 and a LATENCY=0 instance share stimulus.
// Build with IFU_SRAM_RAND_DELAY_EN defined to exercise the random-latency variant.
module tb_ifu_sram_rd_slave;
  import ifu_sram_rd_slave_pkg::*;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] addrReq = '0;
  logic        addrValid = 1'b0;
  logic        rReady = 1'b0;
  logic        wrEn = 1'b0;
  logic [9:0]  wrAddr = '0;
  logic [31:0] wrData = '0;

  logic        addrReady1, rValid1, addrReady0, rValid0;
  logic [31:0] rData1, rData0;
  logic [1:0]  rResp1, rResp0;

  logic        useLat0 = 1'b0;
  logic        selReady, selValid;
  logic [31:0] selData;
  logic [1:0]  selResp;

  int assertCount = 0;
  int failCount = 0;

  ifu_sram_rd_slave #(.LATENCY(1)) dut (
    .clock(clock), .rstn(rstn),
    .addr_r_addr_i(addrReq), .addr_r_valid_i(addrValid), .addr_r_ready_o(addrReady1),
    .r_data_o(rData1), .r_resp_o(rResp1), .r_valid_o(rValid1), .r_ready_i(rReady),
    .wr_en_i(wrEn), .wr_addr_i(wrAddr), .wr_data_i(wrData)
  );

  ifu_sram_rd_slave #(.LATENCY(0)) dut0 (
    .clock(clock), .rstn(rstn),
    .addr_r_addr_i(addrReq), .addr_r_valid_i(addrValid), .addr_r_ready_o(addrReady0),
    .r_data_o(rData0), .r_resp_o(rResp0), .r_valid_o(rValid0), .r_ready_i(rReady),
    .wr_en_i(wrEn), .wr_addr_i(wrAddr), .wr_data_i(wrData)
  );

  assign selReady = useLat0 ? addrReady0 : addrReady1;
  assign selValid = useLat0 ? rValid0    : rValid1;
  assign selData  = useLat0 ? rData0     : rData1;
  assign selResp  = useLat0 ? rResp0     : rResp1;

  always #5 clock = ~clock;

  // Every comparison funnels through here so the counters stay honest.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Inputs change on the falling edge, away from the sampling edge of the DUT.
  task automatic applyStimulus(input logic [31:0] addr, input logic valid, input logic ready);
    @(negedge clock);
    addrReq   = addr;
    addrValid = valid;
    rReady    = ready;
  endtask

  task automatic writeWord(input logic [9:0] idx, input logic [31:0] data);
    @(negedge clock);
    wrEn = 1'b1; wrAddr = idx; wrData = data;
    @(negedge clock);
    wrEn = 1'b0;
  endtask

  task automatic waitValid(output int lat);
    lat = 0;
    while (!selValid && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    checkOutput("wait_valid", {31'd0, selValid}, 32'd1);
  endtask

  task automatic readTxn(input logic [31:0] addr, input int expLat, input logic [31:0] expData,
                         input logic [1:0] expResp);
    int lat;
    applyStimulus(addr, 1'b1, 1'b1);
    checkOutput("accept_ready", {31'd0, selReady}, 32'd1);
    applyStimulus(addr, 1'b0, 1'b1);
    waitValid(lat);
`ifdef IFU_SRAM_RAND_DELAY_EN
    checkOutput("lat_range", {31'd0, (lat >= 1 && lat <= 15)}, 32'd1);
`else
    checkOutput("latency", lat, expLat);
`endif
    checkOutput("r_data", selData, expData);
    checkOutput("r_resp", {30'd0, selResp}, {30'd0, expResp});
    @(negedge clock);
    checkOutput("back_idle", {31'd0, selReady}, 32'd1);
    checkOutput("valid_drop", {31'd0, selValid}, 32'd0);
  endtask

  task automatic checkNoStray(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      checkOutput("no_stray", {31'd0, selValid}, 32'd0);
    end
  endtask

  initial begin
    int lat;
    $display("[TB] start");

    // Reset state
    repeat (2) @(negedge clock);
    checkOutput("rst_ready", {31'd0, addrReady1}, 32'd0);
    checkOutput("rst_valid", {31'd0, rValid1}, 32'd0);
    checkOutput("rst_resp", {30'd0, rResp1}, 32'd0);
    checkOutput("rst_data", rData1, 32'd0);
    rstn = 1'b1;
    @(negedge clock);
    checkOutput("ready_after_rst", {31'd0, addrReady1}, 32'd1);

    writeWord(10'd0, 32'h0000_0413);
    writeWord(10'd1023, 32'hDEAD_BEEF);
    writeWord(10'd5, 32'h1111_1111);
    writeWord(10'd7, 32'h7000_0007);
    writeWord(10'd9, 32'h0000_0009);

    // Normal reads and error decode
    readTxn(BASE, 1, 32'h0000_0413, RESP_OKAY);
    readTxn(32'h8000_0FFC, 1, 32'hDEAD_BEEF, RESP_OKAY);
    readTxn(32'h8000_0002, 1, 32'h0, RESP_SLVERR);
    readTxn(32'h8000_0FFE, 1, 32'h0, RESP_SLVERR);
    readTxn(32'h8000_1000, 1, 32'h0, RESP_DECERR);
    readTxn(32'h7FFF_FFFC, 1, 32'h0, RESP_DECERR);
    readTxn(32'h8000_1002, 1, 32'h0, RESP_DECERR);
    readTxn(32'h0000_0000, 1, 32'h0, RESP_DECERR);

`ifndef IFU_SRAM_RAND_DELAY_EN
    useLat0 = 1'b1;
    readTxn(32'h8000_0FFC, 0, 32'hDEAD_BEEF, RESP_OKAY);
    readTxn(32'h8000_0002, 0, 32'h0, RESP_SLVERR);
    useLat0 = 1'b0;

    // Collision: write lands on the same edge that samples the array
    applyStimulus(BASE + 32'h1C, 1'b1, 1'b1);
    @(negedge clock);
    addrValid = 1'b0; wrEn = 1'b1; wrAddr = 10'd7; wrData = 32'h7777_0001;
    @(negedge clock);
    wrEn = 1'b0;
    checkOutput("coll_valid", {31'd0, rValid1}, 32'd1);
    checkOutput("coll_data", rData1, 32'h7777_0001);
    @(negedge clock);
    checkOutput("coll_idle", {31'd0, addrReady1}, 32'd1);
`endif

    // Backpressure with a late write to the word being returned
    applyStimulus(BASE + 32'h14, 1'b1, 1'b0);
    checkOutput("bp_accept", {31'd0, addrReady1}, 32'd1);
    applyStimulus(BASE + 32'h18, 1'b1, 1'b0);
    checkOutput("bp_busy_ready", {31'd0, addrReady1}, 32'd0);
    waitValid(lat);
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_valid", {31'd0, rValid1}, 32'd1);
      checkOutput("bp_data", rData1, 32'h1111_1111);
      checkOutput("bp_resp", {30'd0, rResp1}, 32'd0);
      checkOutput("bp_ready", {31'd0, addrReady1}, 32'd0);
      if (k == 0) begin
        wrEn = 1'b1; wrAddr = 10'd5; wrData = 32'h5555_5555;
      end else if (k == 4) begin
        addrValid = 1'b0; rReady = 1'b1;
      end
      @(negedge clock);
      wrEn = 1'b0;
    end
    checkOutput("bp_done_valid", {31'd0, rValid1}, 32'd0);
    checkOutput("bp_done_ready", {31'd0, addrReady1}, 32'd1);
    readTxn(BASE + 32'h14, 1, 32'h5555_5555, RESP_OKAY);

    // Reset during WAIT; a write during reset must be dropped
    applyStimulus(BASE, 1'b1, 1'b1);
    @(negedge clock);
    addrValid = 1'b0; rstn = 1'b0;
    wrEn = 1'b1; wrAddr = 10'd9; wrData = 32'h0000_0BAD;
    @(negedge clock);
    checkOutput("rstw_valid", {31'd0, rValid1}, 32'd0);
    checkOutput("rstw_ready_low", {31'd0, addrReady1}, 32'd0);
    rstn = 1'b1; wrEn = 1'b0;
    @(negedge clock);
    checkOutput("rstw_ready", {31'd0, addrReady1}, 32'd1);
    checkNoStray(4);
    readTxn(BASE + 32'h24, 1, 32'h0000_0009, RESP_OKAY);

    // Reset during RESP
    applyStimulus(BASE, 1'b1, 1'b0);
    applyStimulus(BASE, 1'b0, 1'b0);
    waitValid(lat);
    rstn = 1'b0;
    @(negedge clock);
    checkOutput("rstr_valid", {31'd0, rValid1}, 32'd0);
    rstn = 1'b1; rReady = 1'b1;
    @(negedge clock);
    checkOutput("rstr_ready", {31'd0, addrReady1}, 32'd1);
    checkNoStray(4);

`ifdef IFU_SRAM_RAND_DELAY_EN
    for (int i = 0; i < 50; i++) begin
      writeWord(10'(20 + i), {16'hC0DE, 16'(i)});
    end
    for (int i = 0; i < 50; i++) begin
      readTxn(BASE + 32'(4 * (20 + i)), 0, {16'hC0DE, 16'(i)}, RESP_OKAY);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
